reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Per-register pending-write scoreboard for the pipelined ARM core. It tracks, for every architectural register, how many issued instructions still owe a writeback. It stalls ID-stage issue whenever a source operand, or a saturated destination, is still pending. It sits between the ID stage, which presents sources and destination and receives the stall, and the WB stage, which reports retiring writes. It is the producer-side counterpart to the stage-compare hazard check: the same stall decision, derived from tracked state instead of EXE/MEM destination compares.

## Interface
Parameters:
- NUM_REGS, 16, number of tracked architectural registers (R0–R15)
- ADDR_W, 4, register address width; NUM_REGS <= 2**ADDR_W
- CNT_W, 2, per-register pending counter width; max in-flight writes per register = 2**CNT_W-1

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low; clears all state immediately on assertion
- issue_valid  input  1  ID stage presents an instruction this cycle; only commit-guaranteed instructions are presented (no flush path)
- issue_wb_en  input  1  presented instruction writes a register
- issue_dest  input  ADDR_W  destination of presented instruction
- src_1  input  ADDR_W  first source register
- src_2  input  ADDR_W  second source register
- two_src  input  1  src_2 is a real operand
- wb_en  input  1  WB stage retires a register write this cycle
- wb_dest  input  ADDR_W  register being written back
- hazard_detected  output  1  combinational stall request to ID/IF freeze
- issue_accept  output  1  issue_valid & ~hazard_detected
- busy  output  1  any counter nonzero
- pending_total  output  ADDR_W+CNT_W  sum of all counters, registered
- underflow_err  output  1  sticky: writeback arrived for a register with zero pending

## Operation
- State: cnt[r] (CNT_W bits) for r in 0..NUM_REGS-1; pending_total; underflow_err.
- hazard_detected = issue_valid & ( cnt[src_1]!=0 | (two_src & cnt[src_2]!=0) | (issue_wb_en & cnt[issue_dest]==MAX) ), where MAX = 2**CNT_W-1.
- Reads use the registered counts only. A writeback in the same cycle does not clear a hazard; there is no WB bypass.
- inc = issue_accept & issue_wb_en, applied to cnt[issue_dest]. dec = wb_en & cnt[wb_dest]!=0, applied to cnt[wb_dest].
- inc and dec on the same register in the same cycle leave the count unchanged.
- inc and dec on different registers apply independently.
- wb_en with cnt[wb_dest]==0: no counter change; underflow_err set to 1 at the next edge. It stays set until reset.
- Counter never wraps. Saturation is prevented by the MAX stall term, so inc never occurs at MAX.
- pending_total is updated with the same inc/dec: +1, -1, or net 0. busy = pending_total != 0.
- Addresses >= NUM_REGS are ignored for inc/dec and read as count 0.

## Timing
- Reset (rst=0, asynchronous): all cnt=0, pending_total=0, underflow_err=0. Therefore busy=0 and hazard_detected=0 for any inputs, and issue_accept=issue_valid.
- Reset deasserted mid-stream: prior in-flight instructions are forgotten. Subsequent wb_en to zero counts set underflow_err (expected; verification must account for it).
- Issue at edge N with a write to Rd: cnt[Rd] is visible at N+1, and a dependent instruction presented in cycle N+1 stalls.
- Writeback at edge M for Rd, last pending: the dependent instruction is accepted in cycle M+1. Stall latency is therefore issue-to-WB plus one cycle.
- hazard_detected and issue_accept are combinational from inputs and state within the cycle. There is no registered stall output.
- When an instruction is stalled, ID holds its inputs stable. The block requires no handshake beyond issue_valid/issue_accept.

## Test plan
- Reset then idle: hold rst=0 for 2 cycles, release, issue_valid=0 -> hazard_detected=0, busy=0, pending_total=0, underflow_err=0.
- RAW stall: issue R3 write (accepted, cycle 0); cycle 1 present src_1=3 -> hazard_detected=1, issue_accept=0. Then wb_en, wb_dest=3 in cycle 3 -> cycle 4 issue_accept=1, cnt[3]=0.
- two_src gating: cnt[5]=1, present src_1=0, src_2=5, two_src=0 -> no hazard; same with two_src=1 -> hazard_detected=1.
- Saturation: three accepted writes to R7 (cnt=3); fourth write to R7 with independent sources -> hazard_detected=1; one WB to R7 -> next cycle accepted, cnt[7] back to 3, pending_total=3.
- Simultaneous inc/dec on R2 with cnt[2]=1 -> cnt[2] stays 1 and pending_total unchanged. Concurrent inc R4 / dec R2 -> cnt[4]+1, cnt[2]-1, pending_total unchanged.
- Underflow and async reset: wb_en to R9 with cnt=0 -> underflow_err=1 next cycle, counts unchanged. Assert rst=0 mid-cycle -> underflow_err=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: counts outstanding writebacks per
// architectural register and stalls ID issue on pending sources or saturation.
module reg_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    issue_wb_en,
    input  logic [ADDR_W-1:0]       issue_dest,
    input  logic [ADDR_W-1:0]       src_1,
    input  logic [ADDR_W-1:0]       src_2,
    input  logic                    two_src,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       wb_dest,
    output logic                    hazard_detected,
    output logic                    issue_accept,
    output logic                    busy,
    output logic [ADDR_W+CNT_W-1:0] pending_total,
    output logic                    underflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [CNT_W-1:0]    src_1_cnt;
    logic [CNT_W-1:0]    src_2_cnt;
    logic [CNT_W-1:0]    dest_cnt;
    logic [CNT_W-1:0]    wb_cnt;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                inc;
    logic                dec;

    // Address decode by scan: out-of-range addresses never match and read as zero.
    always_comb begin
        src_1_cnt = '0;
        src_2_cnt = '0;
        dest_cnt  = '0;
        wb_cnt    = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (src_1 == ADDR_W'(r))      src_1_cnt = cnt[r];
            if (src_2 == ADDR_W'(r))      src_2_cnt = cnt[r];
            if (issue_dest == ADDR_W'(r)) dest_cnt  = cnt[r];
            if (wb_dest == ADDR_W'(r))    wb_cnt    = cnt[r];
        end
    end

    always_comb begin
        hazard_detected = issue_valid &
                          ((src_1_cnt != '0) |
                           (two_src & (src_2_cnt != '0)) |
                           (issue_wb_en & (dest_cnt == CNT_MAX)));
        issue_accept    = issue_valid & ~hazard_detected;
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = issue_accept & issue_wb_en & (issue_dest == ADDR_W'(r));
            dec_vec[r] = wb_en & (wb_dest == ADDR_W'(r)) & (cnt[r] != '0);
        end
        inc = |inc_vec;
        dec = |dec_vec;
    end

    assign busy = (pending_total != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            pending_total <= '0;
            underflow_err <= 1'b0;
        end else begin
            // Same-register inc/dec cancel; different registers update independently.
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
            if (inc && !dec) begin
                pending_total <= pending_total + 1'b1;
            end else if (dec && !inc) begin
                pending_total <= pending_total - 1'b1;
            end
            if (wb_en && (wb_cnt == '0)) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, reset/underflow sequences,
// and randomized traffic against a per-register counting model.
module tb_reg_scoreboard;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_wb_en;
    logic [3:0] issue_dest;
    logic [3:0] src_1;
    logic [3:0] src_2;
    logic       two_src;
    logic       wb_en;
    logic [3:0] wb_dest;
    logic       hazard_detected;
    logic       issue_accept;
    logic       busy;
    logic [5:0] pending_total;
    logic       underflow_err;

    reg_scoreboard #(.NUM_REGS(16), .ADDR_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
        .src_1(src_1), .src_2(src_2), .two_src(two_src),
        .wb_en(wb_en), .wb_dest(wb_dest),
        .hazard_detected(hazard_detected), .issue_accept(issue_accept),
        .busy(busy), .pending_total(pending_total), .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic       we;
        logic [3:0] d;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic       wbe;
        logic [3:0] wbd;
        logic       hz;
        logic       acc;
        int         tot;
        logic       uf;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int   m[16];
    int   mtot;
    logic muf;

    function automatic vec_t mk(input logic iv, input logic we, input logic [3:0] d,
                                input logic [3:0] s1, input logic [3:0] s2, input logic two,
                                input logic wbe, input logic [3:0] wbd,
                                input logic hz, input logic acc, input int tot, input logic uf);
        vec_t v;
        v.iv = iv; v.we = we; v.d = d; v.s1 = s1; v.s2 = s2; v.two = two;
        v.wbe = wbe; v.wbd = wbd; v.hz = hz; v.acc = acc; v.tot = tot; v.uf = uf;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic we, input logic [3:0] d,
                         input logic [3:0] s1, input logic [3:0] s2, input logic two,
                         input logic wbe, input logic [3:0] wbd);
        issue_valid = iv; issue_wb_en = we; issue_dest = d;
        src_1 = s1; src_2 = s2; two_src = two;
        wb_en = wbe; wb_dest = wbd;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 16; r++) m[r] = 0;
        mtot = 0;
        muf  = 1'b0;
    endtask

    logic [3:0] r_d, r_s1, r_s2, r_wbd;
    logic       r_iv, r_we, r_two, r_wbe;
    logic       e_hz;
    int         pend[$];

    initial begin
        // Directed table, starting from an all-zero scoreboard.
        tbl.push_back(mk(1,1,3,0,0,0,0,0, 0,1,1,0));  // issue R3 write
        tbl.push_back(mk(1,0,0,3,0,0,0,0, 1,0,1,0));  // RAW on R3
        tbl.push_back(mk(1,0,0,3,0,0,0,0, 1,0,1,0));
        tbl.push_back(mk(1,0,0,3,0,0,1,3, 1,0,0,0));  // WB same cycle: no bypass
        tbl.push_back(mk(1,0,0,3,0,0,0,0, 0,1,0,0));  // accepted next cycle
        tbl.push_back(mk(1,1,5,0,0,0,0,0, 0,1,1,0));  // cnt5=1
        tbl.push_back(mk(1,0,0,0,5,0,0,0, 0,1,1,0));  // two_src=0 masks src_2
        tbl.push_back(mk(1,0,0,0,5,1,0,0, 1,0,1,0));  // two_src=1 stalls
        tbl.push_back(mk(0,0,0,0,5,1,1,5, 0,0,0,0));  // no valid -> no hazard
        tbl.push_back(mk(1,1,7,0,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(1,1,7,0,0,0,0,0, 0,1,2,0));
        tbl.push_back(mk(1,1,7,0,0,0,0,0, 0,1,3,0));  // cnt7=MAX
        tbl.push_back(mk(1,1,7,0,0,0,0,0, 1,0,3,0));  // saturation stall
        tbl.push_back(mk(1,1,7,0,0,0,1,7, 1,0,2,0));
        tbl.push_back(mk(1,1,7,0,0,0,0,0, 0,1,3,0));  // accepted after one WB
        tbl.push_back(mk(0,0,0,0,0,0,1,7, 0,0,2,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,7, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,7, 0,0,0,0));
        tbl.push_back(mk(1,1,2,0,0,0,0,0, 0,1,1,0));  // cnt2=1
        tbl.push_back(mk(1,1,2,0,0,0,1,2, 0,1,1,0));  // inc+dec R2 cancel
        tbl.push_back(mk(1,1,4,0,0,0,1,2, 0,1,1,0));  // inc R4, dec R2
        tbl.push_back(mk(1,0,0,4,0,0,0,0, 1,0,1,0));  // R4 pending
        tbl.push_back(mk(0,0,0,0,0,0,1,4, 0,0,0,0));
        tbl.push_back(mk(1,0,0,2,0,0,0,0, 0,1,0,0));  // R2 cleared
        tbl.push_back(mk(0,0,0,0,0,0,1,9, 0,0,0,1));  // underflow on R9

        // Reset held for two cycles, with an issue presented during reset.
        rst = 1'b0;
        drive(1,1,6,1,2,1,1,3);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hazard", hazard_detected, 0);
        check("reset_accept", issue_accept, 1);
        check("reset_busy", busy, 0);
        check("reset_total", pending_total, 0);
        check("reset_uf", underflow_err, 0);
        drive(0,0,0,0,0,0,0,0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_hazard", hazard_detected, 0);
        check("idle_busy", busy, 0);
        check("idle_total", pending_total, 0);
        check("idle_uf", underflow_err, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].we, tbl[i].d, tbl[i].s1, tbl[i].s2,
                  tbl[i].two, tbl[i].wbe, tbl[i].wbd);
            #2;
            check($sformatf("tbl%0d_hazard", i), hazard_detected, tbl[i].hz);
            check($sformatf("tbl%0d_accept", i), issue_accept, tbl[i].acc);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_total", i), pending_total, tbl[i].tot);
            check($sformatf("tbl%0d_busy", i), busy, int'(tbl[i].tot != 0));
            check($sformatf("tbl%0d_uf", i), underflow_err, tbl[i].uf);
        end

        // Underflow is sticky; then a mid-cycle asynchronous reset clears everything.
        drive(1,1,1,0,0,0,0,0);
        @(posedge clk);
        #1;
        check("uf_sticky", underflow_err, 1);
        check("pre_rst_total", pending_total, 1);
        drive(1,0,0,1,0,0,0,0);
        #2;
        check("pre_rst_hazard", hazard_detected, 1);
        #1 rst = 1'b0;
        #1;
        check("async_uf", underflow_err, 0);
        check("async_total", pending_total, 0);
        check("async_busy", busy, 0);
        check("async_hazard", hazard_detected, 0);
        check("async_accept", issue_accept, 1);
        #1 rst = 1'b1;
        drive(0,0,0,0,0,0,0,0);
        @(posedge clk);
        #1;

        // Randomized traffic on R0..R7 against the counting model.
        model_clear();
        for (int i = 0; i < 600; i++) begin
            r_iv  = 1'($urandom_range(0, 3) != 0);
            r_we  = 1'($urandom_range(0, 1));
            r_two = 1'($urandom_range(0, 1));
            r_d   = 4'($urandom_range(0, 7));
            r_s1  = 4'($urandom_range(0, 7));
            r_s2  = 4'($urandom_range(0, 7));
            r_wbe = 1'($urandom_range(0, 1));
            r_wbd = 4'($urandom_range(0, 7));
            pend.delete();
            for (int r = 0; r < 16; r++) if (m[r] > 0) pend.push_back(r);
            if (r_wbe && pend.size() > 0 && $urandom_range(0, 9) < 9)
                r_wbd = 4'(pend[$urandom_range(0, pend.size() - 1)]);
            drive(r_iv, r_we, r_d, r_s1, r_s2, r_two, r_wbe, r_wbd);
            #2;
            e_hz = r_iv && (m[r_s1] != 0 || (r_two && m[r_s2] != 0) || (r_we && m[r_d] == 3));
            check("rnd_hazard", hazard_detected, e_hz);
            check("rnd_accept", issue_accept, int'(r_iv && !e_hz));
            check("rnd_total", pending_total, mtot);
            check("rnd_busy", busy, int'(mtot != 0));
            check("rnd_uf", underflow_err, muf);
            @(posedge clk);
            #1;
            if (r_wbe && m[r_wbd] == 0) muf = 1'b1;
            if (r_wbe && m[r_wbd] != 0) m[r_wbd]--;
            if (r_iv && !e_hz && r_we) m[r_d]++;
            mtot = 0;
            for (int r = 0; r < 16; r++) mtot += m[r];
        end
        check("final_total", pending_total, mtot);
        check("final_uf", underflow_err, muf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
